// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Purpose : Shared definitions for the decode/execute pipeline slice. It holds
//           the datapath widths, the bit positions of the 8-bit decode control
//           vector, a packed view of that vector, the primary opcode constants,
//           and small helpers for splitting the control vector into per-stage
//           groups.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Datapath widths
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned CTRL_W       = 8;
  localparam int unsigned ALUOP_W      = 2;
  localparam int unsigned BUBBLE_CNT_W = 16;

  // Bit positions inside the decode control vector
  localparam int unsigned CTRL_ALUSRC    = 0;
  localparam int unsigned CTRL_ALUOP_LSB = 1;
  localparam int unsigned CTRL_REGDST    = 3;
  localparam int unsigned CTRL_MEMREAD   = 4;
  localparam int unsigned CTRL_MEMWRITE  = 5;
  localparam int unsigned CTRL_REGWRITE  = 6;
  localparam int unsigned CTRL_MEMTOREG  = 7;

  // Primary opcodes of the instructions the decoder recognises
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  // Packed view of the control vector, MSB first, matching the bit positions
  typedef struct packed {
    logic               mem_to_reg;  // [7]
    logic               reg_write;   // [6]
    logic               mem_write;   // [5]
    logic               mem_read;    // [4]
    logic               reg_dst;     // [3]
    logic [ALUOP_W-1:0] alu_op;      // [2:1]
    logic               alu_src;     // [0]
  } ctrl_t;

  // Memory-stage control group {MemWrite, MemRead}
  function automatic logic [1:0] m_group(input ctrl_t c);
    return {c.mem_write, c.mem_read};
  endfunction

  // Write-back control group {MemtoReg, RegWrite}
  function automatic logic [1:0] wb_group(input ctrl_t c);
    return {c.mem_to_reg, c.reg_write};
  endfunction

endpackage : pipe_pkg

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purpose : Combinational load-use comparator. Flags the case where the
//           instruction now in EX is a load whose destination (rt) is read by
//           the instruction now in ID, so one bubble must be inserted.
// Ports   :
//   ex_valid_i     EX holds a real instruction
//   ex_mem_read_i  EX instruction is a load
//   ex_rt_addr_i   EX load destination register
//   id_valid_i     ID holds a real instruction
//   id_flush_i     ID instruction is being killed this cycle
//   id_rs_addr_i   ID source register rs
//   id_rt_addr_i   ID source register rt
//   hazard_o       load-use stall request (combinational)
// ---------------------------------------------------------------------------
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_addr_i,
  input  logic              id_valid_i,
  input  logic              id_flush_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  output logic              hazard_o
);

  logic ex_is_load;
  logic id_live;
  logic addr_match;

  // $0 is hard-wired, so a load targeting it can never create a dependency
  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_addr_i != REG_AW'(0));

  // A flushed ID instruction is dead; holding upstream for it would be wrong
  assign id_live    = id_valid_i & ~id_flush_i;

  assign addr_match = (ex_rt_addr_i == id_rs_addr_i) |
                      (ex_rt_addr_i == id_rt_addr_i);

  assign hazard_o   = ex_is_load & id_live & addr_match;

endmodule : load_use_detect

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// Purpose : ID/EX pipeline register. Captures the decoded control vector,
//           operands, immediate and register addresses for EX, inserts a
//           single bubble on a load-use dependency and requests upstream to
//           hold, and honours external stall and branch/jump flush.
//           Update priority per edge: flush > stall > load-use bubble >
//           invalid ID (bubble) > normal load. Bubbles and flushes clear only
//           control/valid; data and addresses always follow their inputs.
// Optional: define ID_EX_BUBBLE_CNT_EN to add bubble_cnt_o, a saturating
//           count of inserted load-use bubbles.
// Ports   :
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   ctrl_i                decode control vector
//   valid_i               ID holds a real instruction
//   pc_i                  PC+4 of the ID instruction
//   rs_data_i, rt_data_i  register-file read data
//   imm_i                 sign-extended immediate
//   rs_addr_i, rt_addr_i, rd_addr_i  register addresses
//   stall_i               external hold of this register
//   flush_i               kill the instruction entering EX
//   hazard_stall_o        load-use stall request to PC and IF/ID (comb)
//   ex_alusrc_o, ex_aluop_o, ex_regdst_o  EX control
//   m_ctrl_o              {MemWrite, MemRead}
//   wb_ctrl_o             {MemtoReg, RegWrite}
//   valid_o               EX holds a real instruction
//   pc_o, rs_data_o, rt_data_o, imm_o     registered data
//   rs_addr_o, rt_addr_o, rd_addr_o       registered addresses
//   bubble_cnt_o          inserted bubble count (ID_EX_BUBBLE_CNT_EN only)
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hazard_stall_o,
  output logic              ex_alusrc_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_regdst_o,
  output logic [1:0]        m_ctrl_o,
  output logic [1:0]        wb_ctrl_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs_addr_o,
  output logic [REG_AW-1:0] rt_addr_o,
  output logic [REG_AW-1:0] rd_addr_o
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt_o
`endif
);

  import pipe_pkg::ctrl_t;
  import pipe_pkg::m_group;
  import pipe_pkg::wb_group;

  // Registered state
  ctrl_t             ctrl_q,    ctrl_d;
  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;

  logic hazard;

  // Load-use comparator against the instruction currently held in EX
  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_addr_i  (rt_addr_q),
    .id_valid_i    (valid_i),
    .id_flush_i    (flush_i),
    .id_rs_addr_i  (rs_addr_i),
    .id_rt_addr_i  (rt_addr_i),
    .hazard_o      (hazard)
  );

  assign hazard_stall_o = hazard;

  // Next-state selection in priority order
  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;

    if (flush_i || !stall_i) begin
      // Data and addresses follow ID whenever the register is not held
      pc_d      = pc_i;
      rs_data_d = rs_data_i;
      rt_data_d = rt_data_i;
      imm_d     = imm_i;
      rs_addr_d = rs_addr_i;
      rt_addr_d = rt_addr_i;
      rd_addr_d = rd_addr_i;

      if (flush_i || hazard || !valid_i) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = ctrl_t'(ctrl_i);
        valid_d = 1'b1;
      end
    end
  end

  // Pipeline register, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_ins;

  // hazard already excludes flush; a stalled cycle inserts nothing
  assign bubble_ins = hazard & ~stall_i;

  // Saturating bubble counter
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_ins && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

  // Output mapping; ALUOp passes through without reordering
  assign ex_alusrc_o = ctrl_q.alu_src;
  assign ex_aluop_o  = ctrl_q.alu_op;
  assign ex_regdst_o = ctrl_q.reg_dst;
  assign m_ctrl_o    = m_group(ctrl_q);
  assign wb_ctrl_o   = wb_group(ctrl_q);
  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign rs_data_o   = rs_data_q;
  assign rt_data_o   = rt_data_q;
  assign imm_o       = imm_q;
  assign rs_addr_o   = rs_addr_q;
  assign rt_addr_o   = rt_addr_q;
  assign rd_addr_o   = rd_addr_q;

endmodule : id_ex_stage_reg

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Self-checking bench for id_ex_stage_reg. A reference model holds what EX
// should contain after each edge, derived directly from the stage's update
// rules, and every cycle's outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 8;

  localparam logic [7:0] C_LW  = 8'hD1;
  localparam logic [7:0] C_ADD = 8'h4E;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [CW-1:0] ctrl_i;
  logic          valid_i;
  logic [DW-1:0] pc_i, rs_data_i, rt_data_i, imm_i;
  logic [AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
  logic          stall_i, flush_i;
  logic          hazard_stall_o;
  logic          ex_alusrc_o;
  logic [1:0]    ex_aluop_o;
  logic          ex_regdst_o;
  logic [1:0]    m_ctrl_o, wb_ctrl_o;
  logic          valid_o;
  logic [DW-1:0] pc_o, rs_data_o, rt_data_o, imm_o;
  logic [AW-1:0] rs_addr_o, rt_addr_o, rd_addr_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0]   bubble_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model of the EX-side contents
  logic          m_valid;
  logic [7:0]    m_ctrl;
  logic [DW-1:0] m_pc, m_rs, m_rt, m_imm;
  logic [AW-1:0] m_rsa, m_rta, m_rda;
  int            m_cnt;

  id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ctrl_i         (ctrl_i),
    .valid_i        (valid_i),
    .pc_i           (pc_i),
    .rs_data_i      (rs_data_i),
    .rt_data_i      (rt_data_i),
    .imm_i          (imm_i),
    .rs_addr_i      (rs_addr_i),
    .rt_addr_i      (rt_addr_i),
    .rd_addr_i      (rd_addr_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .hazard_stall_o (hazard_stall_o),
    .ex_alusrc_o    (ex_alusrc_o),
    .ex_aluop_o     (ex_aluop_o),
    .ex_regdst_o    (ex_regdst_o),
    .m_ctrl_o       (m_ctrl_o),
    .wb_ctrl_o      (wb_ctrl_o),
    .valid_o        (valid_o),
    .pc_o           (pc_o),
    .rs_data_o      (rs_data_o),
    .rt_data_o      (rt_data_o),
    .imm_o          (imm_o),
    .rs_addr_o      (rs_addr_o),
    .rt_addr_o      (rt_addr_o),
    .rd_addr_o      (rd_addr_o)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt_o   (bubble_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  function automatic void model_clear();
    m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_rs = '0; m_rt = '0; m_imm = '0;
    m_rsa = '0; m_rta = '0; m_rda = '0; m_cnt = 0;
  endfunction

  // Load-use condition against the model's EX contents and current ID inputs
  function automatic logic exp_haz();
    return m_valid && m_ctrl[4] && (m_rta != 0) && valid_i && !flush_i &&
           ((m_rta == rs_addr_i) || (m_rta == rt_addr_i));
  endfunction

  function automatic logic [152:0] exp_bus();
    return {exp_haz(), m_ctrl[0], m_ctrl[2:1], m_ctrl[3], m_ctrl[5], m_ctrl[4],
            m_ctrl[7], m_ctrl[6], m_valid, m_pc, m_rs, m_rt, m_imm, m_rsa, m_rta, m_rda};
  endfunction

  function automatic logic [152:0] act_bus();
    return {hazard_stall_o, ex_alusrc_o, ex_aluop_o, ex_regdst_o, m_ctrl_o,
            wb_ctrl_o, valid_o, pc_o, rs_data_o, rt_data_o, imm_o,
            rs_addr_o, rt_addr_o, rd_addr_o};
  endfunction

  // One rising edge; the model applies the stage's update rules
  task automatic tick();
    logic h;
    h = exp_haz();
    @(posedge clk_i);
    if (rst_i) begin
      model_clear();
    end else begin
      if (flush_i || !stall_i) begin
        m_pc = pc_i; m_rs = rs_data_i; m_rt = rt_data_i; m_imm = imm_i;
        m_rsa = rs_addr_i; m_rta = rt_addr_i; m_rda = rd_addr_i;
        if (flush_i || h || !valid_i) begin
          m_ctrl = '0; m_valid = 1'b0;
        end else begin
          m_ctrl = ctrl_i; m_valid = 1'b1;
        end
      end
      if (h && !stall_i && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [7:0] c,
                          input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd);
    valid_i = v; ctrl_i = c; rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
    pc_i = $urandom; rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive_id(1'b1, 8'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
    #1;
    model_clear();
    checks++;
    if (act_bus() !== 153'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", act_bus());
    end
    for (int i = 0; i < 2; i++) begin
      drive_id(1'b1, 8'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
      tick();
      checks++;
      if (act_bus() !== exp_bus()) begin
        errors++;
        $display("FAIL reset_hold: got %h want %h", act_bus(), exp_bus());
      end
    end
    rst_i = 1'b0;
    drive_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if ({wb_ctrl_o, ex_aluop_o, ex_regdst_o, valid_o} !== 6'b01_11_1_1) begin
      errors++;
      $display("FAIL first_rtype: got wb=%b aluop=%b regdst=%b valid=%b want 01 11 1 1",
               wb_ctrl_o, ex_aluop_o, ex_regdst_o, valid_o);
    end
    checks++;
    if (act_bus() !== exp_bus()) begin
      errors++;
      $display("FAIL first_rtype_bus: got %h want %h", act_bus(), exp_bus());
    end
  endtask

  task automatic test_load_use();
    drive_id(1'b1, C_LW, 5'd2, 5'd5, 5'd0);
    tick();
    drive_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7);
    #1;
    checks++;
    if (hazard_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_hazard: got %b want 1", hazard_stall_o);
    end
    tick();
    checks++;
    if ({valid_o, ex_alusrc_o, ex_aluop_o, ex_regdst_o, m_ctrl_o, wb_ctrl_o,
         hazard_stall_o} !== 10'd0) begin
      errors++;
      $display("FAIL load_use_bubble: got v=%b ctl=%b%b%b%b%b haz=%b want all 0",
               valid_o, ex_alusrc_o, ex_aluop_o, ex_regdst_o, m_ctrl_o, wb_ctrl_o,
               hazard_stall_o);
    end
    checks++;
    if (act_bus() !== exp_bus()) begin
      errors++;
      $display("FAIL load_use_bubble_bus: got %h want %h", act_bus(), exp_bus());
    end
    tick();
    checks++;
    if ({valid_o, rs_addr_o, wb_ctrl_o} !== {1'b1, 5'd5, 2'b01}) begin
      errors++;
      $display("FAIL load_use_enter: got v=%b rs=%0d wb=%b want 1 5 01",
               valid_o, rs_addr_o, wb_ctrl_o);
    end
  endtask

  task automatic test_no_false_hazard();
    drive_id(1'b1, C_LW, 5'd3, 5'd0, 5'd0);
    tick();
    drive_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd4);
    #1;
    checks++;
    if (hazard_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL r0_no_hazard: got %b want 0", hazard_stall_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || act_bus() !== exp_bus()) begin
      errors++;
      $display("FAIL r0_no_bubble: got %h want %h", act_bus(), exp_bus());
    end
    drive_id(1'b1, C_LW, 5'd3, 5'd5, 5'd0);
    tick();
    drive_id(1'b1, C_ADD, 5'd6, 5'd7, 5'd8);
    #1;
    checks++;
    if (hazard_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL indep_no_hazard: got %b want 0", hazard_stall_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || act_bus() !== exp_bus()) begin
      errors++;
      $display("FAIL indep_no_bubble: got %h want %h", act_bus(), exp_bus());
    end
  endtask

  task automatic test_flush_priority();
    drive_id(1'b1, C_LW, 5'd1, 5'd9, 5'd0);
    tick();
    drive_id(1'b1, C_ADD, 5'd9, 5'd2, 5'd3);
    flush_i = 1'b1;
    #1;
    checks++;
    if (hazard_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_masks_hazard: got %b want 0", hazard_stall_o);
    end
    tick();
    flush_i = 1'b0;
    #1;
    checks++;
    if ({valid_o, m_ctrl_o, wb_ctrl_o} !== 5'd0 || act_bus() !== exp_bus()) begin
      errors++;
      $display("FAIL flush_kill: got v=%b m=%b wb=%b want 0 00 00", valid_o, m_ctrl_o, wb_ctrl_o);
    end
  endtask

  task automatic test_stall();
    logic [152:0] snap;
    drive_id(1'b1, C_ADD, 5'd4, 5'd5, 5'd6);
    tick();
    snap = exp_bus();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'($urandom), 8'($urandom), 5'd10, 5'd11, AW'($urandom));
      tick();
      checks++;
      if (act_bus() !== exp_bus() || act_bus() !== snap) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h want %h", i, act_bus(), snap);
      end
    end
    stall_i = 1'b0;
    drive_id(1'b1, C_LW, 5'd12, 5'd13, 5'd0);
    tick();
    checks++;
    if (act_bus() !== exp_bus() || rt_addr_o !== 5'd13) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", act_bus(), exp_bus());
    end
    // Stall during a load-use: request stays up while the condition holds
    drive_id(1'b1, C_ADD, 5'd2, 5'd13, 5'd1);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (hazard_stall_o !== 1'b1 || act_bus() !== exp_bus()) begin
        errors++;
        $display("FAIL stall_hazard_%0d: got %h want %h", i, act_bus(), exp_bus());
      end
      tick();
    end
    stall_i = 1'b0;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b1 || act_bus() !== exp_bus()) begin
      errors++;
      $display("FAIL stall_hazard_resolve: got %h want %h", act_bus(), exp_bus());
    end
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        drive_id(($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 2) == 0) ? C_LW : 8'($urandom),
                 AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 31)));
      end
      stall_i = ($urandom_range(0, 9) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      rst_i   = (i == 150 || i == 151);
      #1;
      if (rst_i) model_clear();
      checks++;
      if (act_bus() !== exp_bus()) begin
        errors++;
        $display("FAIL random_%0d: got %h want %h", i, act_bus(), exp_bus());
      end
      hold = exp_haz() || stall_i;
      tick();
    end
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic test_bubble_cnt();
    rst_i = 1'b1;
    #1;
    model_clear();
    tick();
    rst_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive_id(1'b1, C_LW, 5'd0, AW'(k), 5'd0);
      tick();
      drive_id(1'b1, C_ADD, AW'(k), 5'd0, 5'd2);
      tick();
      tick();
    end
    drive_id(1'b1, C_LW, 5'd0, 5'd7, 5'd0);
    tick();
    drive_id(1'b1, C_ADD, 5'd7, 5'd0, 5'd2);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (bubble_cnt_o !== 16'd3 || int'(bubble_cnt_o) != m_cnt) begin
      errors++;
      $display("FAIL bubble_cnt: got %0d want 3 (model %0d)", bubble_cnt_o, m_cnt);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive_id(1'b0, 8'h00, '0, '0, '0);
    model_clear();
    #3;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_stall();
    test_random();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_bubble_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_id_ex_stage_reg

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the instruction-decode control unit.
- Latches the decoded 8-bit control vector together with operands, immediate and register addresses for the EX stage.
- Contains the load-use hazard detector: it inserts one bubble and raises a stall request back to PC/IF-ID when a load is followed by a dependent instruction.
- Honours external stall and flush (flush comes from taken branch/jump).

Parameters:
- DATA_W, 32, width of PC, operand and immediate data.
- REG_AW, 5, register-file address width.
- CTRL_W, 8, control vector width from decode.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ctrl_i  in  CTRL_W  decode control: [0] ALUSrc, [2:1] ALUOp, [3] RegDst, [4] MemRead, [5] MemWrite, [6] RegWrite, [7] MemtoReg.
- valid_i  in  1  ID holds a real instruction.
- pc_i  in  DATA_W  PC+4 of the ID instruction.
- rs_data_i, rt_data_i  in  DATA_W  register-file read data.
- imm_i  in  DATA_W  sign-extended immediate (funct in [5:0]).
- rs_addr_i, rt_addr_i, rd_addr_i  in  REG_AW  source/destination addresses.
- stall_i  in  1  external hold; freezes this register.
- flush_i  in  1  kill the instruction entering EX.
- hazard_stall_o  out  1  load-use stall request to PC and IF/ID (combinational).
- ex_alusrc_o  out  1  registered ALUSrc.
- ex_aluop_o  out  2  registered ALUOp.
- ex_regdst_o  out  1  registered RegDst.
- m_ctrl_o  out  2  {MemWrite, MemRead}.
- wb_ctrl_o  out  2  {MemtoReg, RegWrite}.
- valid_o  out  1  EX holds a real instruction.
- pc_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data.
- rs_addr_o, rt_addr_o, rd_addr_o  out  REG_AW  registered addresses.

Behaviour:
- Reset: all registered outputs are 0 asynchronously. hazard_stall_o is 0 while in reset, since it is derived from reset-cleared state.
- Latency: one cycle from the ID inputs to the EX outputs.
- Hazard: hazard_stall_o = valid_o & MemRead_q & (rt_addr_o != 0) & valid_i & ~flush_i & ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i)).
- Update priority on each rising edge, highest first:
  - flush_i: control and valid cleared to 0; data and address registers load their inputs.
  - stall_i: every register holds its value.
  - hazard_stall_o: bubble. Control and valid cleared; data and addresses load.
  - valid_i=0: as bubble.
  - otherwise: all registers load their inputs.
- Bubble resolution: upstream holds during a bubble, so the next cycle presents the same instruction. valid_o=0 then drops the hazard and the instruction enters. Load-use penalty is exactly one bubble.
- flush_i and hazard in the same cycle: flush wins and hazard_stall_o is 0, so upstream does not hold the killed instruction.
- stall_i and hazard in the same cycle: registers hold, and hazard_stall_o remains asserted for as long as the condition holds.
- Register $0: a load with destination $0 never triggers a hazard.
- ALUOp: mapped as ctrl_i[2:1] to ex_aluop_o[1:0], with no reordering.
- Reset asserted mid-operation: immediate clear. The first post-reset edge loads normally.

Optional Feature:
- ID_EX_BUBBLE_CNT_EN defined:
  - Adds output bubble_cnt_o, 16 bits.
  - Increments on each edge where a hazard bubble is inserted while stall_i=0 and flush_i=0.
  - Saturates at 16'hFFFF; cleared by rst_i.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W, DATA_W, REG_AW.
  - Control bit indices: CTRL_ALUSRC=0, CTRL_ALUOP_LSB=1, CTRL_REGDST=3, CTRL_MEMREAD=4, CTRL_MEMWRITE=5, CTRL_REGWRITE=6, CTRL_MEMTOREG=7.
  - Opcode constants: R=6'h00, ADDI=6'h08, LW=6'h23, SW=6'h2B, BEQ=6'h04, J=6'h02.
- One natural sub-module: load_use_detect, the combinational comparator producing hazard_stall_o.

Test Plan:
- Reset: rst_i=1 with random inputs -> all outputs 0, hazard_stall_o=0. After release, an R-type input with ctrl_i=8'h4E -> next cycle wb_ctrl_o=2'b01, ex_aluop_o=2'b11, ex_regdst_o=1, valid_o=1.
- Load-use: LW to rt=5 (ctrl_i=8'hD1) followed by ADD with rs=5 -> hazard_stall_o=1 for 1 cycle; one bubble with valid_o=0 and all control 0; the ADD appears the cycle after.
- No false hazard: LW to rt=0 followed by an instruction with rs=0 -> hazard_stall_o=0 and no bubble. LW to rt=5 followed by rs=6, rt=7 -> no bubble.
- Flush priority: flush_i=1 together with a hazard condition -> hazard_stall_o=0; next cycle valid_o=0, m_ctrl_o=0, wb_ctrl_o=0.
- External stall: stall_i=1 for 3 cycles with changing inputs -> all outputs constant. On release, the current inputs load on the next edge.
- With ID_EX_BUBBLE_CNT_EN: 3 load-use pairs plus 1 flushed hazard -> bubble_cnt_o=3.
